// File: rtl/router_pkg.sv
// router_pkg: shared widths, header field positions and read-side FSM states
// for the router output-port reader.
package router_pkg;
   localparam int DATA_W      = 8;
   localparam int LEN_W       = DATA_W - 2;
   localparam int HDR_LEN_LSB = 2;
   localparam int HDR_ADDR_W  = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HDR     = 2'd1,
      PAYLOAD = 2'd2,
      PARITY  = 2'd3
   } rd_state_t;
endpackage

// File: rtl/router_rd_port_if.sv
// router_rd_port_if: FIFO-pop side and byte-stream side of one router read port.
// master is the reader's view, slave is the FIFO/sink environment's view.
interface router_rd_port_if #(
   parameter int DATA_W = router_pkg::DATA_W
);
   logic              vld_out;
   logic [DATA_W-1:0] fifo_data;
   logic              soft_reset;
   logic              read_enb;
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;
   logic              m_sop;
   logic              m_eop;

   modport master (
      input  vld_out, fifo_data, soft_reset, m_ready,
      output read_enb, m_data, m_valid, m_sop, m_eop
   );

   modport slave (
      output vld_out, fifo_data, soft_reset, m_ready,
      input  read_enb, m_data, m_valid, m_sop, m_eop
   );
endinterface

// File: rtl/router_skid2.sv
// router_skid2: two-entry valid/ready holding buffer with synchronous clear.
// all_flag is high when every held entry has bit FLAG_BIT set (also when empty).
module router_skid2 #(
   parameter int W        = 8,
   parameter int FLAG_BIT = 0
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         clear,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic [1:0]   count,
   output logic         all_flag
);
   logic [W-1:0] mem [2];
   logic         rd_ptr;
   logic         wr_ptr;
   logic [1:0]   cnt_q;
   logic         do_push;
   logic         do_pop;

   // a pop frees a slot in the same cycle, so push is accepted even when full
   assign do_pop  = pop & (cnt_q != 2'd0);
   assign do_push = push & ((cnt_q != 2'd2) | do_pop);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         mem[0] <= '0;
         mem[1] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         cnt_q  <= 2'd0;
      end else if (clear) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         cnt_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
      end
   end

   always_comb begin
      all_flag = 1'b1;
      if ((cnt_q != 2'd0) && !mem[rd_ptr][FLAG_BIT]) all_flag = 1'b0;
      if ((cnt_q == 2'd2) && !mem[~rd_ptr][FLAG_BIT]) all_flag = 1'b0;
   end

   assign head  = mem[rd_ptr];
   assign count = cnt_q;
endmodule

// File: rtl/router_rd_port.sv
// router_rd_port: pops one router output FIFO, frames header/payload/parity bytes
// onto a valid/ready stream, checks parity and address, and survives soft_reset flushes.
module router_rd_port #(
   parameter int DATA_W  = router_pkg::DATA_W,
   parameter int LEN_W   = router_pkg::LEN_W,
   parameter int PORT_ID = 0
) (
   input  logic             clock,
   input  logic             resetn,
   router_rd_port_if.master bus,
   output logic             parity_err,
   output logic             addr_err,
   output logic             pkt_abort,
   output logic             busy
);
   import router_pkg::*;

   // skid entry layout: {perr, sop, eop, data}
   localparam int ENT_W    = DATA_W + 3;
   localparam int EOP_BIT  = DATA_W;
   localparam int SOP_BIT  = DATA_W + 1;
   localparam int PERR_BIT = DATA_W + 2;
   localparam logic [HDR_ADDR_W-1:0] MY_ADDR = HDR_ADDR_W'(PORT_ID);

   rd_state_t         state_q, state_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] par_q, par_d;
   logic              run_q;
   logic              rd_inflight;
   logic              abort_q;
   logic              tag_sop, tag_eop, tag_perr;
   logic              push_now, pop_now;
   logic              skid_all_eop;
   logic              partial;
   logic [1:0]        skid_cnt, occ_next;
   logic [ENT_W-1:0]  head;

   assign push_now = rd_inflight & ~bus.soft_reset;
   assign pop_now  = bus.m_valid & bus.m_ready;
   // occupancy once this cycle's push/pop settle; a new read needs one free slot
   assign occ_next = skid_cnt + 2'(push_now) - 2'(pop_now);
   assign bus.read_enb = run_q & bus.vld_out & ~bus.soft_reset & (occ_next < 2'd2);

   assign partial = (state_q == PAYLOAD) | (state_q == PARITY) | ~skid_all_eop;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         par_q       <= '0;
         run_q       <= 1'b0;
         rd_inflight <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         par_q       <= par_d;
         run_q       <= 1'b1;
         rd_inflight <= bus.read_enb;
         abort_q     <= bus.soft_reset & partial;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      par_d   = par_q;
      if (bus.soft_reset) begin
         state_d = HDR;
         cnt_d   = '0;
         par_d   = '0;
      end else if (push_now) begin
         case (state_q)
            IDLE, HDR: begin
               par_d = bus.fifo_data;
               cnt_d = bus.fifo_data[DATA_W-1:HDR_LEN_LSB];
               state_d = (bus.fifo_data[DATA_W-1:HDR_LEN_LSB] == '0) ? PARITY : PAYLOAD;
            end
            PAYLOAD: begin
               par_d = par_q ^ bus.fifo_data;
               cnt_d = cnt_q - LEN_W'(1);
               if (cnt_q == LEN_W'(1)) state_d = PARITY;
            end
            PARITY: begin
               state_d = HDR;
               cnt_d   = '0;
               par_d   = '0;
            end
            default: state_d = HDR;
         endcase
      end
   end

   always_comb begin
      tag_sop  = 1'b0;
      tag_eop  = 1'b0;
      tag_perr = 1'b0;
      case (state_q)
         IDLE, HDR: tag_sop = 1'b1;
         PARITY: begin
            tag_eop  = 1'b1;
            tag_perr = (par_q != bus.fifo_data);
         end
         default: ;
      endcase
   end

   router_skid2 #(.W(ENT_W), .FLAG_BIT(EOP_BIT)) u_skid (
      .clock    (clock),
      .resetn   (resetn),
      .clear    (bus.soft_reset),
      .push     (push_now),
      .pop      (pop_now),
      .din      ({tag_perr, tag_sop, tag_eop, bus.fifo_data}),
      .head     (head),
      .count    (skid_cnt),
      .all_flag (skid_all_eop)
   );

   // error flags travel with their byte and fire only on its handshake
   assign bus.m_valid = (skid_cnt != 2'd0);
   assign bus.m_data  = head[DATA_W-1:0];
   assign bus.m_sop   = bus.m_valid & head[SOP_BIT];
   assign bus.m_eop   = bus.m_valid & head[EOP_BIT];
   assign parity_err  = pop_now & head[PERR_BIT];
   assign addr_err    = pop_now & head[SOP_BIT] & (head[HDR_ADDR_W-1:0] != MY_ADDR);
   assign pkt_abort   = abort_q;
   assign busy        = (state_q != IDLE) | bus.m_valid;
endmodule

// File: tb/tb_router_rd_port.sv
// tb_router_rd_port: directed scenarios for router_rd_port against a FIFO model
// with one-cycle read latency and a stream monitor recording every accepted beat.
module tb_router_rd_port;
   localparam int PORT_ID = 1;

   logic clock  = 1'b0;
   logic resetn = 1'b1;
   logic parity_err, addr_err, pkt_abort, busy;
   int   vec_n = 0;
   int   err_n = 0;

   router_rd_port_if #(.DATA_W(8)) bus ();

   router_rd_port #(.DATA_W(8), .LEN_W(6), .PORT_ID(PORT_ID)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .bus        (bus),
      .parity_err (parity_err),
      .addr_err   (addr_err),
      .pkt_abort  (pkt_abort),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   // FIFO model: flushed by either reset, data appears the cycle after read_enb
   logic [7:0] mem [256];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign bus.vld_out = (wr_ptr != rd_ptr);

   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rd_ptr        <= wr_ptr;
         bus.fifo_data <= 8'h00;
      end else if (bus.soft_reset) begin
         rd_ptr <= wr_ptr;
      end else if (bus.read_enb) begin
         bus.fifo_data <= mem[rd_ptr];
         rd_ptr        <= rd_ptr + 1;
      end
   end

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // beat word: {sop, eop, parity_err, addr_err, data}
   logic [11:0] beat [128];
   int beat_cyc [128];
   int beat_n  = 0;
   int perr_n  = 0;
   int aerr_n  = 0;
   int abort_n = 0;

   always @(negedge clock) begin
      if (bus.m_valid && bus.m_ready && beat_n < 128) begin
         beat[beat_n]     = {bus.m_sop, bus.m_eop, parity_err, addr_err, bus.m_data};
         beat_cyc[beat_n] = cyc;
         beat_n           = beat_n + 1;
      end
      if (parity_err) perr_n = perr_n + 1;
      if (addr_err)   aerr_n = aerr_n + 1;
      if (pkt_abort)  abort_n = abort_n + 1;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic wait_beats(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (beat_n >= target) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      bus.m_ready    = 1'b0;
      bus.soft_reset = 1'b0;
      #2 resetn = 1'b0;
      #2;
      vec_n++;
      if ({bus.read_enb, bus.m_valid, bus.m_sop, bus.m_eop} !== 4'b0000) begin
         err_n++;
         $display("[TB] FAIL reset_outputs: got %b expected 0000",
                  {bus.read_enb, bus.m_valid, bus.m_sop, bus.m_eop});
      end
      vec_n++;
      if ({parity_err, addr_err, pkt_abort} !== 3'b000) begin
         err_n++;
         $display("[TB] FAIL reset_pulses: got %b expected 000", {parity_err, addr_err, pkt_abort});
      end
      vec_n++;
      if (busy !== 1'b0) begin
         err_n++;
         $display("[TB] FAIL reset_busy: got %b expected 0", busy);
      end
      repeat (3) tick();
      resetn = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_basic();
      logic [7:0]  pk [5];
      logic [11:0] exp;
      int base, c0, p0, a0;
      bit ok;
      pk = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
      base = beat_n; p0 = perr_n; a0 = aerr_n;
      bus.m_ready = 1'b1;
      tick();
      c0 = cyc;
      for (int i = 0; i < 5; i++) push_byte(pk[i]);
      #1;
      vec_n++;
      if (bus.read_enb !== 1'b1) begin
         err_n++;
         $display("[TB] FAIL basic_read_issue: got %b expected 1", bus.read_enb);
      end
      wait_beats(base + 5, ok);
      vec_n++;
      if (!ok) begin
         err_n++;
         $display("[TB] FAIL basic_timeout: got %0d beats expected %0d", beat_n - base, 5);
      end
      for (int i = 0; i < 5; i++) begin
         exp = {i == 0, i == 4, 2'b00, pk[i]};
         vec_n++;
         if (beat[base + i] !== exp) begin
            err_n++;
            $display("[TB] FAIL basic_beat%0d: got %h expected %h", i, beat[base + i], exp);
         end
      end
      vec_n++;
      if (beat_cyc[base] !== c0 + 2) begin
         err_n++;
         $display("[TB] FAIL basic_latency: got cycle %0d expected %0d", beat_cyc[base], c0 + 2);
      end
      vec_n++;
      if (beat_cyc[base + 4] - beat_cyc[base] !== 4) begin
         err_n++;
         $display("[TB] FAIL basic_b2b: got span %0d expected 4", beat_cyc[base + 4] - beat_cyc[base]);
      end
      vec_n++;
      if ((perr_n - p0) + (aerr_n - a0) !== 0) begin
         err_n++;
         $display("[TB] FAIL basic_err_pulses: got %0d expected 0", (perr_n - p0) + (aerr_n - a0));
      end
      vec_n++;
      if (busy !== 1'b1) begin
         err_n++;
         $display("[TB] FAIL basic_busy_after: got %b expected 1", busy);
      end
   endtask

   task automatic test_parity_err();
      logic [7:0]  pk [5];
      logic [11:0] exp;
      int base, p0;
      bit ok;
      pk = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C};
      base = beat_n; p0 = perr_n;
      for (int i = 0; i < 5; i++) push_byte(pk[i]);
      wait_beats(base + 5, ok);
      vec_n++;
      if (!ok) begin
         err_n++;
         $display("[TB] FAIL perr_timeout: got %0d beats expected 5", beat_n - base);
      end
      for (int i = 0; i < 5; i++) begin
         exp = {i == 0, i == 4, i == 4, 1'b0, pk[i]};
         vec_n++;
         if (beat[base + i] !== exp) begin
            err_n++;
            $display("[TB] FAIL perr_beat%0d: got %h expected %h", i, beat[base + i], exp);
         end
      end
      repeat (2) tick();
      vec_n++;
      if (perr_n - p0 !== 1) begin
         err_n++;
         $display("[TB] FAIL perr_pulse_count: got %0d expected 1", perr_n - p0);
      end
   endtask

   task automatic test_back_pressure();
      logic [7:0]  pk [6];
      logic [11:0] exp;
      int base, held;
      bit ok;
      pk = '{8'h11, 8'h01, 8'h02, 8'h03, 8'h04, 8'h15};
      base = beat_n;
      for (int i = 0; i < 6; i++) push_byte(pk[i]);
      wait_beats(base + 2, ok);
      bus.m_ready = 1'b0;
      held = beat_n;
      repeat (10) tick();
      vec_n++;
      if ({bus.vld_out, bus.read_enb, bus.m_valid} !== 3'b101) begin
         err_n++;
         $display("[TB] FAIL bp_stall: got vld/rd/valid %b expected 101",
                  {bus.vld_out, bus.read_enb, bus.m_valid});
      end
      vec_n++;
      if (beat_n !== held) begin
         err_n++;
         $display("[TB] FAIL bp_no_accept: got %0d beats expected %0d", beat_n, held);
      end
      bus.m_ready = 1'b1;
      wait_beats(base + 6, ok);
      vec_n++;
      if (!ok) begin
         err_n++;
         $display("[TB] FAIL bp_timeout: got %0d beats expected 6", beat_n - base);
      end
      for (int i = 0; i < 6; i++) begin
         exp = {i == 0, i == 5, 2'b00, pk[i]};
         vec_n++;
         if (beat[base + i] !== exp) begin
            err_n++;
            $display("[TB] FAIL bp_beat%0d: got %h expected %h", i, beat[base + i], exp);
         end
      end
      vec_n++;
      if (beat_cyc[base + 5] - beat_cyc[held] !== 5 - (held - base)) begin
         err_n++;
         $display("[TB] FAIL bp_resume_rate: got span %0d expected %0d",
                  beat_cyc[base + 5] - beat_cyc[held], 5 - (held - base));
      end
   endtask

   task automatic test_soft_reset();
      logic [7:0]  pk [5];
      logic [11:0] exp;
      int base, ab0;
      bit ok;
      pk = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
      base = beat_n;
      push_byte(8'h15);
      for (int i = 1; i <= 5; i++) push_byte(8'hA0 + 8'(i));
      push_byte(8'h5A);
      wait_beats(base + 3, ok);
      ab0 = abort_n;
      bus.soft_reset = 1'b1;
      #1;
      vec_n++;
      if (bus.read_enb !== 1'b0) begin
         err_n++;
         $display("[TB] FAIL sr_read_block: got %b expected 0", bus.read_enb);
      end
      tick();
      bus.soft_reset = 1'b0;
      vec_n++;
      if ({bus.m_valid, pkt_abort} !== 2'b01) begin
         err_n++;
         $display("[TB] FAIL sr_after: got valid/abort %b expected 01", {bus.m_valid, pkt_abort});
      end
      tick();
      vec_n++;
      if (pkt_abort !== 1'b0) begin
         err_n++;
         $display("[TB] FAIL sr_abort_width: got %b expected 0", pkt_abort);
      end
      tick();
      vec_n++;
      if (abort_n - ab0 !== 1) begin
         err_n++;
         $display("[TB] FAIL sr_abort_count: got %0d expected 1", abort_n - ab0);
      end
      base = beat_n;
      for (int i = 0; i < 5; i++) push_byte(pk[i]);
      wait_beats(base + 5, ok);
      for (int i = 0; i < 5; i++) begin
         exp = {i == 0, i == 4, 2'b00, pk[i]};
         vec_n++;
         if (beat[base + i] !== exp) begin
            err_n++;
            $display("[TB] FAIL sr_next_beat%0d: got %h expected %h", i, beat[base + i], exp);
         end
      end
   endtask

   task automatic test_zero_len();
      logic [11:0] exp;
      int base, p0;
      bit ok;
      base = beat_n; p0 = perr_n;
      push_byte(8'h01);
      push_byte(8'h01);
      wait_beats(base + 2, ok);
      for (int i = 0; i < 2; i++) begin
         exp = {i == 0, i == 1, 2'b00, 8'h01};
         vec_n++;
         if (beat[base + i] !== exp) begin
            err_n++;
            $display("[TB] FAIL zlen_beat%0d: got %h expected %h", i, beat[base + i], exp);
         end
      end
      repeat (2) tick();
      vec_n++;
      if (perr_n - p0 !== 0) begin
         err_n++;
         $display("[TB] FAIL zlen_perr: got %0d expected 0", perr_n - p0);
      end
   endtask

   task automatic test_addr_err();
      logic [11:0] exp;
      int base, a0;
      bit ok;
      base = beat_n; a0 = aerr_n;
      push_byte(8'h02);
      push_byte(8'h02);
      wait_beats(base + 2, ok);
      for (int i = 0; i < 2; i++) begin
         exp = {i == 0, i == 1, 1'b0, i == 0, 8'h02};
         vec_n++;
         if (beat[base + i] !== exp) begin
            err_n++;
            $display("[TB] FAIL addr_beat%0d: got %h expected %h", i, beat[base + i], exp);
         end
      end
      repeat (2) tick();
      vec_n++;
      if (aerr_n - a0 !== 1) begin
         err_n++;
         $display("[TB] FAIL addr_pulse_count: got %0d expected 1", aerr_n - a0);
      end
   endtask

   task automatic test_async_reset();
      logic [7:0]  pk [5];
      logic [11:0] exp;
      int base, ab0;
      bit ok;
      pk = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
      base = beat_n;
      push_byte(8'h15);
      for (int i = 1; i <= 5; i++) push_byte(8'hB0 + 8'(i));
      push_byte(8'h77);
      wait_beats(base + 2, ok);
      #2 resetn = 1'b0;
      #1;
      vec_n++;
      if ({bus.read_enb, bus.m_valid, bus.m_sop, bus.m_eop, parity_err, addr_err, pkt_abort, busy}
          !== 8'h00) begin
         err_n++;
         $display("[TB] FAIL areset_outputs: got %b expected 00000000",
                  {bus.read_enb, bus.m_valid, bus.m_sop, bus.m_eop,
                   parity_err, addr_err, pkt_abort, busy});
      end
      @(posedge clock);
      #3 resetn = 1'b1;
      ab0 = abort_n;
      repeat (3) tick();
      vec_n++;
      if (abort_n - ab0 !== 0) begin
         err_n++;
         $display("[TB] FAIL areset_no_abort: got %0d expected 0", abort_n - ab0);
      end
      base = beat_n;
      for (int i = 0; i < 5; i++) push_byte(pk[i]);
      wait_beats(base + 5, ok);
      for (int i = 0; i < 5; i++) begin
         exp = {i == 0, i == 4, 2'b00, pk[i]};
         vec_n++;
         if (beat[base + i] !== exp) begin
            err_n++;
            $display("[TB] FAIL areset_next_beat%0d: got %h expected %h", i, beat[base + i], exp);
         end
      end
   endtask

   initial begin
      bus.m_ready    = 1'b0;
      bus.soft_reset = 1'b0;
      test_reset();
      test_basic();
      test_parity_err();
      test_back_pressure();
      test_soft_reset();
      test_zero_len();
      test_addr_err();
      test_async_reset();
      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
      $finish;
   end
endmodule
